// File: rtl/mux4_sel_sync_if.sv
`default_nettype none
// ============================================================================
// Module   : mux4_sel_sync_if
// Purpose  : Bus bundle for the 4:1 selector: data/select in, three comb and
//            the registered/self-check results out.
// Revision : 1.0
// ============================================================================
interface mux4_sel_sync_if #(
    parameter int DW = 1
);
    logic [4*DW-1:0] in;
    logic [1:0]      sel;
    logic            in_valid;
    logic [DW-1:0]   out_inst;
    logic [DW-1:0]   out_if;
    logic [DW-1:0]   out_case;
    logic [DW-1:0]   out_q;
    logic            out_valid;
    logic            mismatch;

    modport master (
        output in, sel, in_valid,
        input  out_inst, out_if, out_case, out_q, out_valid, mismatch
    );

    modport slave (
        input  in, sel, in_valid,
        output out_inst, out_if, out_case, out_q, out_valid, mismatch
    );
endinterface
`default_nettype wire

// File: rtl/mux4_sel_sync.sv
`default_nettype none
// ============================================================================
// Module   : mux4_sel_sync
// Purpose  : 4:1 selector coded three ways (gate tree, if-chain, case) with a
//            registered result and a sticky cross-check flag.
// Revision : 1.0
// ============================================================================

// 2:1 mux cell built from gate primitives: y = s ? b : a, bitwise over DW.
module mux4_sel_sync_mux2 #(
    parameter int DW = 1
) (
    input  wire [DW-1:0] a,
    input  wire [DW-1:0] b,
    input  wire          s,
    output wire [DW-1:0] y
);
    wire w_s_n;
    not u_inv (w_s_n, s);

    genvar gi;
    generate
        for (gi = 0; gi < DW; gi = gi + 1) begin : g_bit
            wire w_pa;
            wire w_pb;
            and u_and_a (w_pa, a[gi], w_s_n);
            and u_and_b (w_pb, b[gi], s);
            or  u_or    (y[gi], w_pa, w_pb);
        end
    endgenerate
endmodule

module mux4_sel_sync #(
    parameter int DW = 1
) (
    input  wire             clk,
    input  wire             rst,
    mux4_sel_sync_if.slave  bus
);
    logic [DW-1:0] w_lane0;
    logic [DW-1:0] w_lane1;
    logic [DW-1:0] w_lane2;
    logic [DW-1:0] w_lane3;

    assign w_lane0 = bus.in[0*DW +: DW];
    assign w_lane1 = bus.in[1*DW +: DW];
    assign w_lane2 = bus.in[2*DW +: DW];
    assign w_lane3 = bus.in[3*DW +: DW];

    // Structural path: sel[0] picks within each pair, sel[1] picks the pair.
    wire [DW-1:0] w_lvl1_lo;
    wire [DW-1:0] w_lvl1_hi;
    wire [DW-1:0] w_inst;

    mux4_sel_sync_mux2 #(.DW(DW)) u_mux_lo (
        .a (w_lane0), .b (w_lane1), .s (bus.sel[0]), .y (w_lvl1_lo)
    );
    mux4_sel_sync_mux2 #(.DW(DW)) u_mux_hi (
        .a (w_lane2), .b (w_lane3), .s (bus.sel[0]), .y (w_lvl1_hi)
    );
    mux4_sel_sync_mux2 #(.DW(DW)) u_mux_top (
        .a (w_lvl1_lo), .b (w_lvl1_hi), .s (bus.sel[1]), .y (w_inst)
    );

    assign bus.out_inst = w_inst;

    logic [DW-1:0] w_if;
    always_comb begin
        w_if = '0;
        if ($isunknown(bus.sel)) begin
            w_if = '0;
        end else if (bus.sel == 2'd0) begin
            w_if = w_lane0;
        end else if (bus.sel == 2'd1) begin
            w_if = w_lane1;
        end else if (bus.sel == 2'd2) begin
            w_if = w_lane2;
        end else begin
            w_if = w_lane3;
        end
    end
    assign bus.out_if = w_if;

    logic [DW-1:0] w_case;
    always_comb begin
        w_case = '0;
        case (bus.sel)
            2'd0:    w_case = w_lane0;
            2'd1:    w_case = w_lane1;
            2'd2:    w_case = w_lane2;
            2'd3:    w_case = w_lane3;
            default: w_case = '0;
        endcase
    end
    assign bus.out_case = w_case;

    // The check reads the bus copies so any override on the outputs is seen.
    logic [DW-1:0] res_d, res_q;
    logic          vld_d, vld_q;
    logic          mis_d, mis_q;

    always_comb begin
        vld_d = bus.in_valid;
        res_d = bus.in_valid ? bus.out_case : res_q;
        mis_d = mis_q | (bus.in_valid &
                         ((bus.out_inst != bus.out_if) | (bus.out_if != bus.out_case)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            vld_q <= 1'b0;
            mis_q <= 1'b0;
        end else begin
            res_q <= res_d;
            vld_q <= vld_d;
            mis_q <= mis_d;
        end
    end

    assign bus.out_q     = res_q;
    assign bus.out_valid = vld_q;
    assign bus.mismatch  = mis_q;
endmodule
`default_nettype wire

// File: tb/tb_mux4_sel_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_sel_sync
// Purpose  : Self-checking bench for mux4_sel_sync (DW=1 and DW=4 instances).
// Revision : 1.0
// ============================================================================
module tb_mux4_sel_sync;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mux4_sel_sync_if #(.DW(1)) if1 ();
    mux4_sel_sync_if #(.DW(4)) if4 ();

    mux4_sel_sync #(.DW(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    mux4_sel_sync #(.DW(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Scoreboard entries: {expected out_valid, expected out_q} for the DW=1 DUT.
    logic [1:0] sb_q[$];
    logic       model_out;

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (if1.out_q !== 1'b0) begin
            failures++; $display("FAIL reset_out_q got=%b exp=0", if1.out_q);
        end
        checks++;
        if (if1.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=0", if1.out_valid);
        end
        checks++;
        if (if1.mismatch !== 1'b0) begin
            failures++; $display("FAIL reset_mismatch got=%b exp=0", if1.mismatch);
        end
        checks++;
        if (if4.out_q !== 4'h0) begin
            failures++; $display("FAIL reset_out_q_dw4 got=%h exp=0", if4.out_q);
        end
        @(negedge clk);
        rst = 1'b0;
        model_out = 1'b0;
    endtask

    task automatic test_comb_vectors();
        logic [3:0] vin [10];
        logic [1:0] vsel[10];
        logic       vexp[10];
        vin = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                4'b0010, 4'b0011, 4'b1011, 4'b1001, 4'b0011, 4'b0000};
        vsel = '{2'b00, 2'b01, 2'b10, 2'b11,
                 2'b10, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01};
        vexp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        if1.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if1.in  = vin[i];
            if1.sel = vsel[i];
            #50;
            checks++;
            if (if1.out_inst !== vexp[i]) begin
                failures++;
                $display("FAIL vec%0d_inst in=%b sel=%b got=%b exp=%b", i, vin[i], vsel[i], if1.out_inst, vexp[i]);
            end
            checks++;
            if (if1.out_if !== vexp[i]) begin
                failures++;
                $display("FAIL vec%0d_if in=%b sel=%b got=%b exp=%b", i, vin[i], vsel[i], if1.out_if, vexp[i]);
            end
            checks++;
            if (if1.out_case !== vexp[i]) begin
                failures++;
                $display("FAIL vec%0d_case in=%b sel=%b got=%b exp=%b", i, vin[i], vsel[i], if1.out_case, vexp[i]);
            end
        end
    endtask

    task automatic test_sweep();
        logic [5:0] idx;
        logic [3:0] tin;
        logic [1:0] tsel;
        logic       texp;
        logic [1:0] ent;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            idx  = i[5:0];
            tin  = idx[5:2];
            tsel = idx[1:0];
            texp = tin[tsel];
            if1.in = tin; if1.sel = tsel; if1.in_valid = 1'b1;
            model_out = texp;
            sb_q.push_back({1'b1, model_out});
            #40;
            checks++;
            if ({if1.out_inst, if1.out_if, if1.out_case} !== {3{texp}}) begin
                failures++;
                $display("FAIL sweep_comb in=%b sel=%b got=%b%b%b exp=%b", tin, tsel,
                         if1.out_inst, if1.out_if, if1.out_case, texp);
            end
            @(posedge clk);
            #1;
            checks++;
            if (sb_q.size() == 0) begin
                failures++; $display("FAIL sweep_sb_empty got=0 exp=1");
            end else begin
                ent = sb_q.pop_front();
                if ({if1.out_valid, if1.out_q} !== ent) begin
                    failures++;
                    $display("FAIL sweep_reg in=%b sel=%b got=%b%b exp=%b", tin, tsel,
                             if1.out_valid, if1.out_q, ent);
                end
            end
        end
        checks++;
        if (if1.mismatch !== 1'b0) begin
            failures++; $display("FAIL sweep_mismatch got=%b exp=0", if1.mismatch);
        end
        @(negedge clk);
        if1.in_valid = 1'b0;
    endtask

    task automatic test_registered();
        logic [1:0] ent;
        test_reset();
        // Load lane3, then drop in_valid: result must hold.
        for (int step = 0; step < 3; step++) begin
            if (step > 0) @(negedge clk);
            if (step == 0) begin
                if1.in = 4'b1000; if1.sel = 2'b11; if1.in_valid = 1'b1;
                model_out = 1'b1;
                sb_q.push_back({1'b1, model_out});
            end else begin
                if1.in = 4'b0000; if1.sel = 2'b00; if1.in_valid = 1'b0;
                sb_q.push_back({1'b0, model_out});
            end
            @(posedge clk);
            #1;
            checks++;
            if (sb_q.size() == 0) begin
                failures++; $display("FAIL reg_sb_empty got=0 exp=1");
            end else begin
                ent = sb_q.pop_front();
                if ({if1.out_valid, if1.out_q} !== ent) begin
                    failures++;
                    $display("FAIL reg_step%0d got=%b%b exp=%b", step, if1.out_valid, if1.out_q, ent);
                end
            end
        end
    endtask

    task automatic test_sync_reset();
        @(negedge clk);
        if1.in = 4'b0001; if1.sel = 2'b00; if1.in_valid = 1'b1;
        @(posedge clk);
        #10;
        rst = 1'b1;
        #20;
        checks++;
        if ({if1.out_valid, if1.out_q} !== 2'b11) begin
            failures++; $display("FAIL srst_between_edges got=%b%b exp=11", if1.out_valid, if1.out_q);
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({if1.out_valid, if1.out_q, if1.mismatch} !== 3'b000) begin
                failures++;
                $display("FAIL srst_cycle%0d got=%b%b%b exp=000", c, if1.out_valid, if1.out_q, if1.mismatch);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        if1.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({if1.out_valid, if1.out_q} !== 2'b00) begin
            failures++; $display("FAIL srst_release got=%b%b exp=00", if1.out_valid, if1.out_q);
        end
    endtask

    task automatic test_dw4_fault();
        test_reset();
        if4.in = 16'hDCBA; if4.sel = 2'b10; if4.in_valid = 1'b1;
        #40;
        checks++;
        if ({if4.out_inst, if4.out_if, if4.out_case} !== 12'hCCC) begin
            failures++;
            $display("FAIL dw4_comb got=%h%h%h exp=ccc", if4.out_inst, if4.out_if, if4.out_case);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({if4.out_valid, if4.mismatch, if4.out_q} !== 6'b10_1100) begin
            failures++;
            $display("FAIL dw4_reg got=v%b m%b q%h exp=v1 m0 qc", if4.out_valid, if4.mismatch, if4.out_q);
        end
        @(negedge clk);
        force if4.out_inst = 4'h3;
        @(posedge clk);
        #1;
        checks++;
        if (if4.mismatch !== 1'b1) begin
            failures++; $display("FAIL dw4_fault_detect got=%b exp=1", if4.mismatch);
        end
        @(negedge clk);
        release if4.out_inst;
        if4.sel = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (if4.mismatch !== 1'b1 || if4.out_q !== 4'hB) begin
            failures++;
            $display("FAIL dw4_sticky got=m%b q%h exp=m1 qb", if4.mismatch, if4.out_q);
        end
        @(negedge clk);
        if4.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (if4.mismatch !== 1'b0) begin
            failures++; $display("FAIL dw4_mismatch_clear got=%b exp=0", if4.mismatch);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        if1.in = '0; if1.sel = '0; if1.in_valid = 1'b0;
        if4.in = '0; if4.sel = '0; if4.in_valid = 1'b0;
        model_out = 1'b0;
        test_reset();
        test_comb_vectors();
        test_sweep();
        test_registered();
        test_sync_reset();
        test_dw4_fault();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
